// File: rtl/mem_ctrl_rr.sv
// mem_ctrl_rr: round-robin arbitrated multi-channel access to one on-chip word RAM
// Optional feature: define MEM_CTRL_WSTRB_EN to add per-byte write strobes (ch_wstrb).
module mem_ctrl_rr #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10,
    parameter int NUM_CH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_CH-1:0]          ch_valid,
    output logic [NUM_CH-1:0]          ch_ready,
    input  logic [NUM_CH-1:0]          ch_write,
    input  logic [NUM_CH*ADDR_W-1:0]   ch_addr,
    input  logic [NUM_CH*DATA_W-1:0]   ch_wdata,
`ifdef MEM_CTRL_WSTRB_EN
    input  logic [NUM_CH*DATA_W/8-1:0] ch_wstrb,
`endif
    output logic                       resp_valid,
    output logic [$clog2(NUM_CH)-1:0]  resp_ch,
    output logic [DATA_W-1:0]          resp_rdata,
    output logic                       busy
);
    localparam int CH_W = $clog2(NUM_CH);
    localparam int NB = DATA_W / 8;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            r_state;
    logic [CH_W-1:0]   r_rr_ptr;
    logic [CH_W-1:0]   r_ch;
    logic              r_write;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_mem [2**ADDR_W];
`ifdef MEM_CTRL_WSTRB_EN
    logic [NB-1:0]     r_wstrb;
`endif

    logic [NUM_CH-1:0] w_rot;
    logic [CH_W:0]     w_sum;
    logic [CH_W-1:0]   w_gnt;
    logic [CH_W-1:0]   w_nxt;
    logic              w_take;
    logic [NB-1:0]     w_wstrb;

    // Rotate valids so rr_ptr sits at bit 0, pick the lowest set bit, rotate the index back
    always_comb begin
        w_rot = NUM_CH'({ch_valid, ch_valid} >> r_rr_ptr);
        w_sum = '0;
        for (int k = NUM_CH - 1; k >= 0; k--)
            if (w_rot[k]) w_sum = {1'b0, r_rr_ptr} + (CH_W+1)'(k);
        w_gnt = CH_W'((w_sum >= (CH_W+1)'(NUM_CH)) ? w_sum - (CH_W+1)'(NUM_CH) : w_sum);
        w_nxt = (w_gnt == CH_W'(NUM_CH - 1)) ? '0 : w_gnt + 1'b1;
        w_take = (r_state == IDLE) && (|ch_valid) && !rst;
        ch_ready = w_take ? NUM_CH'(1) << w_gnt : '0;
    end

`ifdef MEM_CTRL_WSTRB_EN
    assign w_wstrb = r_wstrb;
`else
    assign w_wstrb = '1;
`endif

    // Two-state access FSM: grant and capture in IDLE, perform the access in BUSY
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_rr_ptr   <= '0;
            busy       <= 1'b0;
            resp_valid <= 1'b0;
            resp_ch    <= '0;
            resp_rdata <= '0;
        end else begin
            resp_valid <= 1'b0;
            if (r_state == IDLE) begin
                if (w_take) begin
                    r_state  <= BUSY;
                    busy     <= 1'b1;
                    r_rr_ptr <= w_nxt;
                    r_ch     <= w_gnt;
                    r_write  <= ch_write[w_gnt];
                    r_addr   <= ch_addr[w_gnt*ADDR_W +: ADDR_W];
                    r_wdata  <= ch_wdata[w_gnt*DATA_W +: DATA_W];
`ifdef MEM_CTRL_WSTRB_EN
                    r_wstrb  <= ch_wstrb[w_gnt*NB +: NB];
`endif
                end
            end else begin
                r_state <= IDLE;
                busy    <= 1'b0;
                if (!r_write) begin
                    resp_valid <= 1'b1;
                    resp_ch    <= r_ch;
                    resp_rdata <= r_mem[r_addr];
                end
            end
        end
    end

    // RAM byte-lane writes land at the end of the write's BUSY cycle; contents are never reset
    always_ff @(posedge clk) begin
        if (r_state == BUSY && r_write && !rst)
            for (int b = 0; b < NB; b++)
                if (w_wstrb[b]) r_mem[r_addr][b*8 +: 8] <= r_wdata[b*8 +: 8];
    end
endmodule

// File: tb/tb_mem_ctrl_rr.sv
// tb_mem_ctrl_rr: directed scoreboard bench for mem_ctrl_rr (default parameters)
module tb_mem_ctrl_rr;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  ch_valid = '0;
    logic [1:0]  ch_ready;
    logic [1:0]  ch_write = '0;
    logic [19:0] ch_addr = '0;
    logic [63:0] ch_wdata = '0;
`ifdef MEM_CTRL_WSTRB_EN
    logic [7:0]  ch_wstrb = '0;
`endif
    logic        resp_valid;
    logic        resp_ch;
    logic [31:0] resp_rdata;
    logic        busy;

    typedef struct {logic ch; logic [31:0] data; int cyc;} exp_t;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          ptr = 0;
    exp_t        sb[$];
    exp_t        mon_e;
    int          gseq[$];
    logic [31:0] mdl [int];
    logic [3:0]  strb [2];
    logic [31:0] last_rd = '0;

    mem_ctrl_rr dut (
        .clk(clk),
        .rst(rst),
        .ch_valid(ch_valid),
        .ch_ready(ch_ready),
        .ch_write(ch_write),
        .ch_addr(ch_addr),
        .ch_wdata(ch_wdata),
`ifdef MEM_CTRL_WSTRB_EN
        .ch_wstrb(ch_wstrb),
`endif
        .resp_valid(resp_valid),
        .resp_ch(resp_ch),
        .resp_rdata(resp_rdata),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Response monitor: every pulse must match the oldest expected read, in the expected cycle
    always @(negedge clk) begin
        if (resp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("resp_unexpected", resp_valid, 0);
            end else begin
                mon_e = sb.pop_front();
                chk("resp_ch", resp_ch, mon_e.ch);
                chk("resp_rdata", resp_rdata, mon_e.data);
                chk("resp_cycle", cyc, mon_e.cyc);
            end
            last_rd = resp_rdata;
        end
    end

    task automatic set_req(input int c, input logic w, input logic [9:0] a,
                           input logic [31:0] d, input logic [3:0] s);
        ch_valid[c] = 1'b1;
        ch_write[c] = w;
        ch_addr[c*10 +: 10] = a;
        ch_wdata[c*32 +: 32] = d;
        strb[c] = s;
`ifdef MEM_CTRL_WSTRB_EN
        ch_wstrb[c*4 +: 4] = s;
`endif
    endtask

    task automatic model_op(input int g);
        logic [9:0]  a;
        logic [31:0] d;
        logic [31:0] nv;
        a = ch_addr[g*10 +: 10];
        d = ch_wdata[g*32 +: 32];
        if (ch_write[g]) begin
`ifdef MEM_CTRL_WSTRB_EN
            nv = mdl.exists(int'(a)) ? mdl[int'(a)] : 32'h0;
            for (int b = 0; b < 4; b++)
                if (strb[g][b]) nv[b*8 +: 8] = d[b*8 +: 8];
`else
            nv = d;
`endif
            mdl[int'(a)] = nv;
        end else begin
            sb.push_back('{g[0], mdl[int'(a)], cyc + 2});
        end
    endtask

    // Called at a falling edge; runs grants until no valid is left and the last BUSY is over.
    // hold=0: each channel drops valid after its grant; hold=N: valids stay up for N grants.
    task automatic serve(input int hold);
        logic [1:0] drop = '0;
        logic [1:0] want;
        logic       prev = 1'b0;
        int         g;
        int         grants = 0;
        for (int n = 0; n < 100; n++) begin
            ch_valid = ch_valid & ~drop;
            drop = '0;
            if (ch_valid == 2'b00 && !prev) return;
            #1;
            if (prev) begin
                chk("busy_high", busy, 1);
                chk("ready_in_busy", ch_ready, 0);
                prev = 1'b0;
            end else begin
                chk("busy_low", busy, 0);
                g = ch_valid[ptr] ? ptr : 1 - ptr;
                want = '0;
                want[g] = 1'b1;
                chk("grant", ch_ready, want);
                gseq.push_back(g);
                model_op(g);
                ptr = (g + 1) % 2;
                prev = 1'b1;
                grants++;
                if (hold == 0) drop[g] = 1'b1;
                else if (grants == hold) drop = 2'b11;
            end
            @(negedge clk);
        end
        chk("serve_timeout", ch_valid, 0);
    endtask

    task automatic drain();
        repeat (4) @(negedge clk);
        #1;
        chk("scoreboard_empty", sb.size(), 0);
        chk("resp_idle", resp_valid, 0);
        chk("rdata_hold", resp_rdata, last_rd);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset with both valids high
        rst = 1'b1;
        set_req(0, 1'b0, 10'd0, 32'h0, 4'hF);
        set_req(1, 1'b0, 10'd0, 32'h0, 4'hF);
        repeat (2) begin
            @(negedge clk);
            #1;
            chk("rst_ready", ch_ready, 0);
            chk("rst_resp_valid", resp_valid, 0);
            chk("rst_busy", busy, 0);
        end
        chk("rst_resp_ch", resp_ch, 0);
        chk("rst_resp_rdata", resp_rdata, 0);
        ch_valid = '0;
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("idle_busy", busy, 0);
        chk("idle_ready", ch_ready, 0);
        @(negedge clk);

        // 2: write then read back on ch0
        set_req(0, 1'b1, 10'd0, 32'd42, 4'hF);
        serve(0);
        set_req(0, 1'b0, 10'd0, 32'h0, 4'hF);
        serve(0);
        drain();
        chk("t2_rdata", last_rd, 42);

        // 3: simultaneous reads after pointer returns to ch0
        set_req(0, 1'b1, 10'd5, 32'h55, 4'hF);
        serve(0);
        set_req(1, 1'b1, 10'd6, 32'h66, 4'hF);
        serve(0);
        gseq.delete();
        set_req(0, 1'b0, 10'd5, 32'h0, 4'hF);
        set_req(1, 1'b0, 10'd6, 32'h0, 4'hF);
        serve(0);
        drain();
        chk("t3_ngrants", gseq.size(), 2);
        if (gseq.size() == 2) begin
            chk("t3_first", gseq[0], 0);
            chk("t3_second", gseq[1], 1);
        end
        chk("t3_last_rdata", last_rd, 32'h66);

        // 4: both channels held valid for 8 grants
        gseq.delete();
        set_req(0, 1'b0, 10'd5, 32'h0, 4'hF);
        set_req(1, 1'b0, 10'd6, 32'h0, 4'hF);
        serve(8);
        drain();
        chk("t4_ngrants", gseq.size(), 8);
        foreach (gseq[i]) chk("t4_seq", gseq[i], i % 2);

        // 5: top address, full write then strobed write, then read
        set_req(0, 1'b1, 10'd1023, 32'hAABBCCDD, 4'hF);
        serve(0);
        set_req(0, 1'b1, 10'd1023, 32'h00000011, 4'b0001);
        serve(0);
        set_req(0, 1'b0, 10'd1023, 32'h0, 4'h0);
        serve(0);
        drain();
`ifdef MEM_CTRL_WSTRB_EN
        chk("t5_rdata", last_rd, 32'hAABBCC11);
`else
        chk("t5_rdata", last_rd, 32'h00000011);
`endif

        // 6: ch1 read accepted, reset in its BUSY cycle drops the response
        set_req(1, 1'b0, 10'd6, 32'h0, 4'h0);
        #1;
        chk("t6_ready", ch_ready, 2'b10);
        @(negedge clk);
        ch_valid = '0;
        rst = 1'b1;
        #1;
        chk("t6_busy", busy, 1);
        @(negedge clk);
        rst = 1'b0;
        ptr = 0;
        repeat (3) begin
            #1;
            chk("t6_no_resp", resp_valid, 0);
            chk("t6_idle", busy, 0);
            @(negedge clk);
        end
        set_req(0, 1'b0, 10'd0, 32'h0, 4'hF);
        serve(0);
        drain();
        chk("t6_after_rst", last_rd, 42);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
